// File: rtl/countdown_module.sv
// Loadable down-counter with ready/valid load port and one-cycle terminal-count pulse.
// Optional auto-reload from DONE is enabled by defining COUNTDOWN_AUTO_RELOAD_EN.
//
// state | meaning
// IDLE  | waiting for a load, count held at 0, load_ready high
// RUN   | counting down on en, stop aborts to IDLE
// DONE  | single-cycle terminal-count pulse, count is 0
module countdown_module #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             stop,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] reload;

  // Outputs are registered alongside the state so each always equals its state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      reload     <= '0;
      load_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid && load_ready) begin
            reload     <= load_value;
            load_ready <= 1'b0;
            if (load_value != '0) begin
              state <= RUN;
              count <= load_value;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              count <= '0;
              done  <= 1'b1;
            end
          end
        end

        RUN: begin
          if (stop) begin
            state      <= IDLE;
            count      <= '0;
            busy       <= 1'b0;
            load_ready <= 1'b1;
          end else if (en) begin
            if (count == WIDTH'(1)) begin
              state <= DONE;
              count <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              count <= count - WIDTH'(1);
            end
          end
        end

        DONE: begin
          done <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          if (reload != '0) begin
            state <= RUN;
            count <= reload;
            busy  <= 1'b1;
          end else begin
            state      <= IDLE;
            load_ready <= 1'b1;
          end
`else
          state      <= IDLE;
          load_ready <= 1'b1;
`endif
        end

        default: begin
          state      <= IDLE;
          count      <= '0;
          load_ready <= 1'b1;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule
